// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser states and stack opcodes for the voice scheduler.
// Kept in one package so the parser and the note stack agree on encodings.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CTRL     = 4'hB;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IGNORE,
        ST_WAIT_D1,
        ST_WAIT_D2
    } parser_state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_REMOVE,
        OP_CLEAR
    } stack_op_e;

    // Status nibbles whose messages feed the note stack.
    function automatic logic is_voice_status(input logic [3:0] nib);
        return (nib == NOTE_OFF) || (nib == NOTE_ON) || (nib == CTRL);
    endfunction

endpackage

// File: rtl/midi_voice_stack.sv
// Last-note-priority stack of held notes. Slot 0 is the oldest entry, slot count-1 the top;
// unused slots are kept at zero so shifting in from above naturally clears the vacated slot.
module midi_voice_stack
    import midi_pkg::*;
#(
    parameter int VOICES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  stack_op_e                   i_op,
    input  logic [6:0]                  i_note,
    input  logic [6:0]                  i_velocity,
    output logic [6:0]                  o_top_note,
    output logic [6:0]                  o_top_velocity,
    output logic [$clog2(VOICES+1)-1:0] o_count,
    output logic                        o_overflow
);

    localparam int CW = $clog2(VOICES + 1);
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [6:0]        r_note [VOICES];
    logic [6:0]        r_vel  [VOICES];
    logic [CW-1:0]     r_count;
    logic [6:0]        r_top_note;
    logic [6:0]        r_top_vel;
    logic              r_overflow;

    logic [VOICES-1:0] w_match;
    logic              w_hit;
    logic              w_full;
    logic              w_is_push;
    logic              w_is_remove;
    logic              w_is_clear;
    logic              w_do_shift;
    logic [IW-1:0]     w_hit_idx;
    logic [IW-1:0]     w_shift_idx;
    logic [CW-1:0]     w_base_count;
    logic [CW-1:0]     w_count_next;
    logic [6:0]        w_note_next [VOICES];
    logic [6:0]        w_vel_next  [VOICES];
    logic [6:0]        w_top_note_next;
    logic [6:0]        w_top_vel_next;
    logic              w_overflow_next;

    assign w_is_push   = (i_op == OP_PUSH);
    assign w_is_remove = (i_op == OP_REMOVE);
    assign w_is_clear  = (i_op == OP_CLEAR);

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_match
            assign w_match[gi] = (CW'(gi) < r_count) && (r_note[gi] == i_note);
        end
    endgenerate

    // The stack never holds duplicates, so at most one match bit is set.
    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (w_match[i]) begin
                w_hit_idx = IW'(i);
            end
        end
    end

    assign w_hit  = |w_match;
    assign w_full = (r_count == CW'(VOICES));

    // A hit (push or remove) closes the gap at the hit slot; a full-stack miss evicts slot 0.
    assign w_do_shift   = (w_is_push && (w_hit || w_full)) || (w_is_remove && w_hit);
    assign w_shift_idx  = w_hit ? w_hit_idx : '0;
    assign w_base_count = w_do_shift ? (r_count - CW'(1)) : r_count;

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_slot
            logic [6:0] w_up_note;
            logic [6:0] w_up_vel;
            logic [6:0] w_sh_note;
            logic [6:0] w_sh_vel;

            if (gi == VOICES - 1) begin : g_top_slot
                assign w_up_note = '0;
                assign w_up_vel  = '0;
            end else begin : g_inner_slot
                assign w_up_note = r_note[gi+1];
                assign w_up_vel  = r_vel[gi+1];
            end

            assign w_sh_note = (w_do_shift && (IW'(gi) >= w_shift_idx)) ? w_up_note : r_note[gi];
            assign w_sh_vel  = (w_do_shift && (IW'(gi) >= w_shift_idx)) ? w_up_vel  : r_vel[gi];

            always_comb begin
                w_note_next[gi] = w_sh_note;
                w_vel_next[gi]  = w_sh_vel;
                if (w_is_clear) begin
                    w_note_next[gi] = '0;
                    w_vel_next[gi]  = '0;
                end else if (w_is_push && (CW'(gi) == w_base_count)) begin
                    w_note_next[gi] = i_note;
                    w_vel_next[gi]  = i_velocity;
                end
            end
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        unique case (i_op)
            OP_CLEAR:  w_count_next = '0;
            OP_PUSH:   w_count_next = w_base_count + CW'(1);
            OP_REMOVE: w_count_next = w_base_count;
            default:   w_count_next = r_count;
        endcase
    end

    assign w_overflow_next = w_is_push && !w_hit && w_full;

    // Top entry is looked up from the next state so the outputs stay fully registered.
    always_comb begin
        w_top_note_next = '0;
        w_top_vel_next  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (CW'(i + 1) == w_count_next) begin
                w_top_note_next = w_note_next[i];
                w_top_vel_next  = w_vel_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
            end
            r_count    <= '0;
            r_top_note <= '0;
            r_top_vel  <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= w_note_next[i];
                r_vel[i]  <= w_vel_next[i];
            end
            r_count    <= w_count_next;
            r_top_note <= w_top_note_next;
            r_top_vel  <= w_top_vel_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_top_note     = r_top_note;
    assign o_top_velocity = r_top_vel;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;

endmodule

// File: rtl/midi_voice_scheduler.sv
// MIDI channel-voice parser with running status driving a last-note-priority voice stack.
// Outputs the single sounding note, its velocity and gate, all registered.
module midi_voice_scheduler
    import midi_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        panic,
    output logic                        gate,
    output logic [6:0]                  note,
    output logic [6:0]                  velocity,
    output logic [$clog2(VOICES+1)-1:0] voice_count,
    output logic                        overflow,
    output logic [7:0]                  led_out
);

    localparam logic [3:0] CH = 4'(CHANNEL);

    parser_state_e r_state;
    parser_state_e w_state_next;
    logic [3:0]    r_status;
    logic [3:0]    w_status_next;
    logic [6:0]    r_d1;
    logic [6:0]    w_d1_next;
    stack_op_e     w_event_op;
    stack_op_e     w_stack_op;
    logic          w_chan_ok;

    assign w_chan_ok = (OMNI != 0) || (rx_data[3:0] == CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_status <= '0;
            r_d1     <= '0;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
            r_d1     <= w_d1_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_d1_next     = r_d1;
        w_event_op    = OP_NOP;
        if (rx_valid) begin
            if (rx_data[7]) begin
                // Realtime bytes (F8..FF) fall through untouched so a partial message survives.
                if (rx_data < 8'hF8) begin
                    if (rx_data >= 8'hF0) begin
                        w_state_next  = ST_IDLE;
                        w_status_next = '0;
                    end else if (is_voice_status(rx_data[7:4]) && w_chan_ok) begin
                        w_state_next  = ST_WAIT_D1;
                        w_status_next = rx_data[7:4];
                    end else begin
                        w_state_next  = ST_IGNORE;
                        w_status_next = '0;
                    end
                end
            end else begin
                unique case (r_state)
                    ST_WAIT_D1: begin
                        w_d1_next    = rx_data[6:0];
                        w_state_next = ST_WAIT_D2;
                    end
                    ST_WAIT_D2: begin
                        w_state_next = ST_WAIT_D1;
                        if (r_status == NOTE_ON) begin
                            w_event_op = (rx_data[6:0] != 7'd0) ? OP_PUSH : OP_REMOVE;
                        end else if (r_status == NOTE_OFF) begin
                            w_event_op = OP_REMOVE;
                        end else if ((r_status == CTRL) &&
                                     ((r_d1 == CC_ALL_NOTES_OFF) || (r_d1 == CC_ALL_SOUND_OFF))) begin
                            w_event_op = OP_CLEAR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Panic overrides whatever event the parser produced this cycle.
    assign w_stack_op = panic ? OP_CLEAR : w_event_op;

    midi_voice_stack #(
        .VOICES(VOICES)
    ) u_stack (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_op           (w_stack_op),
        .i_note         (r_d1),
        .i_velocity     (rx_data[6:0]),
        .o_top_note     (note),
        .o_top_velocity (velocity),
        .o_count        (voice_count),
        .o_overflow     (overflow)
    );

    assign gate    = (voice_count != '0);
    assign led_out = {gate, note};

endmodule

// File: tb/tb_midi_voice_scheduler.sv
// Scoreboard bench for midi_voice_scheduler: expected output states are queued as the
// final byte of each message is driven and popped once the DUT has registered it.
module tb_midi_voice_scheduler;

    localparam int VOICES = 4;
    localparam int CW     = $clog2(VOICES + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          panic = 1'b0;
    logic          gate;
    logic [6:0]    note;
    logic [6:0]    velocity;
    logic [CW-1:0] voice_count;
    logic          overflow;
    logic [7:0]    led_out;

    midi_voice_scheduler #(
        .VOICES  (VOICES),
        .CHANNEL (0),
        .OMNI    (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .panic       (panic),
        .gate        (gate),
        .note        (note),
        .velocity    (velocity),
        .voice_count (voice_count),
        .overflow    (overflow),
        .led_out     (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       gate;
        logic [6:0] note;
        logic [6:0] vel;
        int         cnt;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [6:0] nt, input logic [6:0] vl,
                                input int cnt, input logic ovf);
        exp_t e;
        e.tag  = tag;
        e.gate = (cnt != 0);
        e.note = nt;
        e.vel  = vl;
        e.cnt  = cnt;
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        logic [7:0] led_exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb_q.pop_front();
            led_exp = e.gate ? {1'b1, e.note} : 8'h00;
            check({e.tag, ".gate"},  32'(gate),        32'(e.gate));
            check({e.tag, ".note"},  32'(note),        32'(e.note));
            check({e.tag, ".vel"},   32'(velocity),    32'(e.vel));
            check({e.tag, ".count"}, 32'(voice_count), 32'(e.cnt));
            check({e.tag, ".ovf"},   32'(overflow),    32'(e.ovf));
            check({e.tag, ".led"},   32'(led_out),     32'(led_exp));
            $display("[TB] %s: gate=%0d note=0x%02h vel=0x%02h count=%0d ovf=%0d led=0x%02h",
                     e.tag, gate, note, velocity, voice_count, overflow, led_out);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pnc = 1'b0);
        rx_data  = b;
        rx_valid = 1'b1;
        panic    = pnc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        panic    = 1'b0;
    endtask

    task automatic xact(input string tag, input logic [7:0] b, input logic [6:0] nt,
                        input logic [6:0] vl, input int cnt, input logic ovf = 1'b0,
                        input logic pnc = 1'b0);
        expect_state(tag, nt, vl, cnt, ovf);
        send(b, pnc);
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 7'h00, 7'h00, 0, 1'b0);
        compare_out();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Running status on note-on, velocity 0 acting as note-off.
        send(8'h90);
        send(8'h3C);
        xact("rs_push1", 8'h40, 7'h3C, 7'h40, 1);
        send(8'h3E);
        xact("rs_push2", 8'h50, 7'h3E, 7'h50, 2);
        send(8'h3E);
        xact("rs_vel0_off", 8'h00, 7'h3C, 7'h40, 1);
        send(8'h3C);
        xact("rs_empty", 8'h00, 7'h00, 7'h00, 0);

        // Removal from the middle keeps last-note priority.
        send(8'h90);
        send(8'h3C);
        xact("mid_push_3c", 8'h40, 7'h3C, 7'h40, 1);
        send(8'h40);
        xact("mid_push_40", 8'h41, 7'h40, 7'h41, 2);
        send(8'h43);
        xact("mid_push_43", 8'h42, 7'h43, 7'h42, 3);
        send(8'h80);
        send(8'h40);
        xact("mid_rm_40", 8'h00, 7'h43, 7'h42, 2);
        send(8'h43);
        xact("mid_rm_43", 8'h00, 7'h3C, 7'h40, 1);
        send(8'hB0);
        send(8'h7B);
        xact("cc123_clear", 8'h00, 7'h00, 7'h00, 0);

        // Overflow evicts the oldest entry.
        send(8'h90);
        for (int i = 0; i < 4; i++) begin
            send(8'h30 + 8'(i));
            xact($sformatf("ovf_push_%0d", i), 8'h10 + 8'(i), 7'h30 + 7'(i), 7'h10 + 7'(i), i + 1);
        end
        send(8'h34);
        xact("ovf_push_evict", 8'h14, 7'h34, 7'h14, 4, 1'b1);
        expect_state("ovf_pulse_end", 7'h34, 7'h14, 4, 1'b0);
        @(posedge clk);
        #1;
        compare_out();
        send(8'h80);
        send(8'h31);
        xact("ovf_rm_31", 8'h00, 7'h34, 7'h14, 3);
        send(8'h32);
        xact("ovf_rm_32", 8'h00, 7'h34, 7'h14, 2);
        send(8'h33);
        xact("ovf_rm_33", 8'h00, 7'h34, 7'h14, 1);
        send(8'h34);
        xact("ovf_rm_34", 8'h00, 7'h00, 7'h00, 0);
        send(8'h90);
        send(8'h30);
        xact("ovf_30_gone", 8'h00, 7'h00, 7'h00, 0);

        // Retrigger of a held note, other CC no-op, CC120 clear via running status.
        send(8'h50);
        xact("re_push_50", 8'h20, 7'h50, 7'h20, 1);
        send(8'h51);
        xact("re_push_51", 8'h21, 7'h51, 7'h21, 2);
        send(8'h50);
        xact("re_retrig_50", 8'h30, 7'h50, 7'h30, 2);
        send(8'h50);
        xact("re_rm_50", 8'h00, 7'h51, 7'h21, 1);
        send(8'hB0);
        send(8'h07);
        xact("cc7_noop", 8'h64, 7'h51, 7'h21, 1);
        send(8'h78);
        xact("cc120_clear", 8'h00, 7'h00, 7'h00, 0);

        // Channel filter and realtime byte inside a message.
        send(8'h91);
        send(8'h3C);
        xact("other_chan", 8'h40, 7'h00, 7'h00, 0);
        send(8'h90);
        send(8'h3C);
        xact("realtime_mid", 8'hF8, 7'h00, 7'h00, 0);
        xact("realtime_push", 8'h40, 7'h3C, 7'h40, 1);

        // Panic on the final byte wins; the parser still advances.
        send(8'h45);
        xact("panic_wins", 8'h40, 7'h00, 7'h00, 0, 1'b0, 1'b1);
        send(8'h46);
        xact("after_panic", 8'h41, 7'h46, 7'h41, 1);

        // SysEx and unsupported status drop data bytes.
        send(8'hF0);
        send(8'h47);
        xact("sysex_data", 8'h48, 7'h46, 7'h41, 1);
        send(8'hC0);
        xact("prog_change", 8'h05, 7'h46, 7'h41, 1);

        // Reset in the middle of a message.
        send(8'h90);
        send(8'h3C);
        rst_n = 1'b0;
        #2;
        expect_state("rst_async", 7'h00, 7'h00, 0, 1'b0);
        compare_out();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xact("rst_d2_ignored", 8'h40, 7'h00, 7'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_voice_scheduler.md
Name: midi_voice_scheduler

Overview:
Sits between the MIDI UART byte receiver and the LED/display output stage. It consumes completed bytes, parses channel-voice messages (with running status), and keeps a last-note-priority stack of held notes. It drives the single output resource: the one note that is currently sounding, plus its gate and velocity. It replaces ad-hoc "wait for 0x9n, then note, then 0x8n" sequencing with correct handling of polyphony, running status and stuck notes.

Parameters:
VOICES, 4, depth of the held-note stack (2..8)
CHANNEL, 0, MIDI channel 0..15 to respond to
OMNI, 0, 1 = respond to all channels and ignore CHANNEL

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
rx_data  in  8  completed byte from the receiver
rx_valid  in  1  single-cycle strobe; rx_data is valid on this cycle only
panic  in  1  synchronous request to clear all held voices
gate  out  1  1 while at least one note is held
note  out  7  note number of the top-of-stack entry
velocity  out  7  velocity of the top-of-stack entry
voice_count  out  $clog2(VOICES+1)  number of held notes
overflow  out  1  one-cycle pulse when a push evicts the oldest entry
led_out  out  8  {gate, note}; all zeros when gate=0

Behaviour:
- Reset (rst_n=0, asynchronous): parser goes to IDLE, running status is cleared, stack is emptied, and every output is 0.
- Parser states: IDLE, IGNORE, WAIT_D1, WAIT_D2. Only cycles with rx_valid=1 advance the parser.
- Byte 0xF8..0xFF (realtime): no effect in any state; the partial message is kept.
- Byte 0xF0..0xF7: go to IDLE and clear running status.
- Status 0x8n/0x9n/0xBn with matching channel (or OMNI=1): latch the status, discard any partial message, go to WAIT_D1.
- Any other status 0x80..0xEF: go to IGNORE.
- Data bytes (bit7=0) in IDLE or IGNORE are discarded.
- WAIT_D1 + data byte: latch d1, go to WAIT_D2.
- WAIT_D2 + data byte: execute the event, then return to WAIT_D1 (running status).
- Events:
  - 0x9n with vel>0: PUSH(d1, vel).
  - 0x8n, or 0x9n with vel=0: REMOVE(d1).
  - 0xBn with d1=123 (all notes off) or d1=120: CLEAR.
  - Any other 0xBn message: no-op.
- PUSH:
  - If the note is already present, delete it and compact, then place it on top with the new velocity. voice_count is unchanged.
  - Else if count < VOICES, place on top and increment count.
  - Else discard the bottom (oldest) entry, shift down, place on top, and pulse overflow for exactly 1 cycle.
- REMOVE:
  - If present, delete the entry and compact, preserving the order of the others. The top becomes the next most recent entry.
  - If absent, no change.
- CLEAR and panic: count becomes 0 and the stack is emptied.
- panic together with an executing event in the same cycle: panic wins; the event is dropped. The parser still advances normally.
- Latency: the stack and all outputs update on the clock edge that samples the final data byte, so they are visible in the following cycle. Outputs are registered, with no combinational path from rx_data.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss. There is no backpressure.
- note and velocity equal the top-of-stack entry while gate=1. When count=0 they are held at 0.
- Stack search is fully parallel over VOICES entries. All operations complete in a single cycle.

Decomposition:
- Shared package midi_pkg:
  - Status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB).
  - CC_ALL_NOTES_OFF=7'd123, CC_ALL_SOUND_OFF=7'd120.
  - Parser state enum.
  - Stack opcode enum (NOP, PUSH, REMOVE, CLEAR).
- Sub-module midi_voice_stack:
  - Inputs: opcode, note, velocity.
  - Outputs: top entry, count, overflow.
  - Owns the storage and the compaction logic.
- The parser FSM stays in midi_voice_scheduler.

Test Plan:
- Running status: send 0x90 3C 40 3E 50 -> after the last byte, note=0x3E, velocity=0x50, voice_count=2, led_out=0xBE. Then send 3E 00 -> note=0x3C, count=1.
- Last-note priority with removal from the middle: push 0x3C, 0x40, 0x43, then send 0x80 40 00 -> top stays 0x43, count=2. Then send 0x80 43 00 -> top=0x3C.
- Overflow with VOICES=4: push 0x30, 0x31, 0x32, 0x33, 0x34 -> overflow pulses for 1 cycle, count=4. Then remove 0x31..0x34 -> gate=0; 0x30 was evicted.
- Channel filter with CHANNEL=0: 0x91 3C 40 -> no change. An interleaved 0xF8 inside 0x90 3C F8 40 -> note 0x3C is pushed.
- Clear paths: 0xB0 7B 00 -> count=0, led_out=0x00. A panic pulse on the same cycle as the final byte of 0x90 45 40 -> count=0.
- Reset mid-message: 0x90 3C, then assert rst_n=0, release, send 40 -> ignored (IDLE), all outputs 0.
